// File: rtl/cpu_run_controller_pkg.sv
// Shared types for the core run controller: FSM state encoding, load-command
// priority, and the instruction-RAM word capacity.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RESET  = 3'd2,
    ST_READY  = 3'd3,
    ST_RUN    = 3'd4,
    ST_STEP   = 3'd5,
    ST_HALTED = 3'd6,
    ST_FAULT  = 3'd7
  } state_e;

  // Higher encoding wins when several host commands arrive together.
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_STEP = 2'd2,
    CMD_LOAD = 2'd3
  } cmd_e;

  function automatic int unsigned max_words(input int unsigned addr_width);
    return 32'd1 << (addr_width - 2);
  endfunction

  function automatic cmd_e pick_cmd(input logic load, input logic step, input logic run);
    if (load) return CMD_LOAD;
    if (step) return CMD_STEP;
    if (run)  return CMD_RUN;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/cpu_run_controller_sat_counter.sv
// Up-counter with synchronous clear (dominant) and enable; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (en && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the pipelined core: program load into instruction RAM,
// core reset sequencing, and free-run / bounded-run / single-step fetch gating.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int RESET_CYCLES = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [31:0]           load_data,
  output logic                  load_ready,
  input  logic                  load_done,
  input  logic                  run_start,
  input  logic                  step_req,
  input  logic                  halt_req,
  input  logic [CNT_WIDTH-1:0]  run_limit,
  input  logic                  data_access_fault_exception,
  output logic                  debug_enable,
  output logic                  core_rst,
  output logic                  instruction_write,
  output logic [31:0]           instruction_in,
  output logic [2:0]            state,
  output logic [ADDR_WIDTH-2:0] load_count,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  load_overflow
);

  localparam int LW = ADDR_WIDTH - 1;
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [LW-1:0] MAX_CNT  = LW'(max_words(ADDR_WIDTH));
  localparam logic [RW-1:0] RST_INIT = RW'(RESET_CYCLES - 1);

  state_e           state_q, state_d;
  cmd_e             cmd;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [LW-1:0]    load_count_q, load_count_d;
  logic             load_overflow_q, load_overflow_d;
  logic             load_ready_q, load_ready_d;
  logic             instruction_write_q, instruction_write_d;
  logic [31:0]      instruction_in_q, instruction_in_d;
  logic             debug_enable_q, debug_enable_d;
  logic             core_rst_q, core_rst_d;
  logic [CNT_WIDTH-1:0] run_cnt;
  logic             run_hit, accept, fault;

  assign fault  = data_access_fault_exception;
  assign accept = (state_q == ST_LOAD) && load_valid && load_ready_q;
  // run_cnt holds enabled cycles already completed in this run, so the current
  // cycle is the last one when run_cnt + 1 reaches the budget.
  assign run_hit = (run_limit != '0) &&
                   (({1'b0, run_cnt} + (CNT_WIDTH+1)'(1)) == {1'b0, run_limit});

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cmd       = pick_cmd(load_start, step_req, run_start);
    case (state_q)
      ST_IDLE:  if (load_start) state_d = ST_LOAD;
      ST_LOAD:  if (load_done)  state_d = ST_RESET;
      ST_RESET: begin
        if (rst_cnt_q == '0) state_d = ST_READY;
        else                 rst_cnt_d = rst_cnt_q - RW'(1);
      end
      ST_READY, ST_HALTED: begin
        if ((state_q == ST_HALTED) && fault) state_d = ST_FAULT;
        else begin
          case (cmd)
            CMD_LOAD: state_d = ST_LOAD;
            CMD_STEP: state_d = ST_STEP;
            CMD_RUN:  state_d = ST_RUN;
            default:  state_d = state_q;
          endcase
        end
      end
      ST_RUN: begin
        if (fault)                    state_d = ST_FAULT;
        else if (halt_req || run_hit) state_d = ST_HALTED;
      end
      ST_STEP:  state_d = fault ? ST_FAULT : ST_HALTED;
      ST_FAULT: if (load_start) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
    if ((state_d == ST_RESET) && (state_q != ST_RESET)) rst_cnt_d = RST_INIT;
  end

  always_comb begin
    load_count_d        = load_count_q;
    load_overflow_d     = load_overflow_q;
    instruction_write_d = accept;
    instruction_in_d    = accept ? load_data : instruction_in_q;
    if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
      load_count_d    = '0;
      load_overflow_d = 1'b0;
    end else if (accept) begin
      load_count_d = load_count_q + LW'(1);
    end else if ((state_q == ST_LOAD) && load_valid && (load_count_q == MAX_CNT)) begin
      load_overflow_d = 1'b1;
    end
    // Registered from next-cycle values so ready drops right after the last slot fills.
    load_ready_d   = (state_d == ST_LOAD) && (load_count_d < MAX_CNT);
    debug_enable_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    core_rst_d     = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_RESET);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= ST_IDLE;
      rst_cnt_q           <= '0;
      load_count_q        <= '0;
      load_overflow_q     <= 1'b0;
      load_ready_q        <= 1'b0;
      instruction_write_q <= 1'b0;
      instruction_in_q    <= '0;
      debug_enable_q      <= 1'b0;
      core_rst_q          <= 1'b1;
    end else begin
      state_q             <= state_d;
      rst_cnt_q           <= rst_cnt_d;
      load_count_q        <= load_count_d;
      load_overflow_q     <= load_overflow_d;
      load_ready_q        <= load_ready_d;
      instruction_write_q <= instruction_write_d;
      instruction_in_q    <= instruction_in_d;
      debug_enable_q      <= debug_enable_d;
      core_rst_q          <= core_rst_d;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr ((state_d == ST_RESET) && (state_q != ST_RESET)),
    .en  (debug_enable_q),
    .cnt (cycle_count)
  );

  sat_counter #(.W(CNT_WIDTH)) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .clr ((state_d == ST_RUN) && (state_q != ST_RUN)),
    .en  (state_q == ST_RUN),
    .cnt (run_cnt)
  );

  assign state             = state_q;
  assign load_count        = load_count_q;
  assign load_overflow     = load_overflow_q;
  assign load_ready        = load_ready_q;
  assign instruction_write = instruction_write_q;
  assign instruction_in    = instruction_in_q;
  assign debug_enable      = debug_enable_q;
  assign core_rst          = core_rst_q;

endmodule
